// File: rtl/ece593w26_div.sv
// ece593w26_div -- sequential signed restoring divider.
//
// Takes a two's-complement dividend/divisor pair on a start pulse, works on
// unsigned magnitudes one quotient bit per clock, then applies the signs:
// the quotient truncates toward zero and the remainder takes the dividend's sign.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   start                 request, accepted only while idle
//   dividend, divisor     signed operands, captured when start is accepted
//   busy                  operation in progress
//   done                  one-cycle pulse when the result registers update
//   quotient, remainder   signed results, held until the next done
//   div_by_zero, overflow status of the last completed op, held until next done
module ece593w26_div #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] ZERO = '0;
    localparam logic [WIDTH-1:0] MINV = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, PREP, DIV, FIX} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;      // captured dividend (sign kept in MSB)
    logic [WIDTH-1:0] dvs_q, dvs_d;      // captured divisor
    logic             qneg_q, qneg_d;
    logic             zero_q, zero_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH:0]   pr_q, pr_d;        // partial remainder, one guard bit
    logic [WIDTH-1:0] qm_q, qm_d;        // dividend magnitude, becomes quotient magnitude
    logic [WIDTH-1:0] sm_q, sm_d;        // divisor magnitude
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dbz_q, dbz_d;
    logic             ovfo_q, ovfo_d;

    logic [WIDTH:0]   pr_sh, trial;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            qneg_q  <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            pr_q    <= '0;
            qm_q    <= '0;
            sm_q    <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
            ovfo_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            qneg_q  <= qneg_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            pr_q    <= pr_d;
            qm_q    <= qm_d;
            sm_q    <= sm_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
            ovfo_q  <= ovfo_d;
        end
    end

    // One restoring step: shift {pr, qm} left, trial-subtract the divisor magnitude.
    assign pr_sh = {pr_q[WIDTH-1:0], qm_q[WIDTH-1]};
    assign trial = pr_sh - {1'b0, sm_q};

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        qneg_d  = qneg_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        pr_d    = pr_q;
        qm_d    = qm_q;
        sm_d    = sm_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;
        ovfo_d  = ovfo_q;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    qneg_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                    zero_d  = (divisor == ZERO);
                    ovf_d   = (dividend == MINV) && (divisor == '1);
                    busy_d  = 1'b1;
                    state_d = (divisor == ZERO) ? FIX : PREP;
                end
            end
            PREP: begin
                // Negating MINV yields 2^(WIDTH-1), which is the correct unsigned magnitude.
                qm_d    = dvd_q[WIDTH-1] ? (ZERO - dvd_q) : dvd_q;
                sm_d    = dvs_q[WIDTH-1] ? (ZERO - dvs_q) : dvs_q;
                pr_d    = '0;
                cnt_d   = CW'(WIDTH);
                state_d = DIV;
            end
            DIV: begin
                if (!trial[WIDTH]) begin
                    pr_d = trial;
                    qm_d = {qm_q[WIDTH-2:0], 1'b1};
                end else begin
                    pr_d = pr_sh;
                    qm_d = {qm_q[WIDTH-2:0], 1'b0};
                end
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = FIX;
            end
            FIX: begin
                if (zero_q) begin
                    quot_d = '1;
                    rem_d  = dvd_q;
                    dbz_d  = 1'b1;
                    ovfo_d = 1'b0;
                end else begin
                    quot_d = qneg_q ? (ZERO - qm_q) : qm_q;
                    rem_d  = dvd_q[WIDTH-1] ? (ZERO - pr_q[WIDTH-1:0]) : pr_q[WIDTH-1:0];
                    dbz_d  = 1'b0;
                    ovfo_d = ovf_q;
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign overflow    = ovfo_q;

endmodule
